// File: rtl/dsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dsm_pkg
//  Purpose  : Definitions shared by the delta-sigma modulator and its
//             PCM sample feeder: sample width, oversample ratio and the
//             sample type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package dsm_pkg;

  localparam int SAMPLE_W = 16;
  localparam int OSR      = 256;

  // Oversample frame counter runs 0..OSR-1, so the terminal count is FF.
  localparam logic [7:0] OSR_TC = 8'hFF;

  // Modulator comparison point: unsigned mid-scale.
  localparam logic [SAMPLE_W-1:0] THRESHOLD = 16'h8000;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Returns the next frame-counter value, wrapping at the terminal count.
  function automatic logic [7:0] osr_next(input logic [7:0] cnt);
    return (cnt == OSR_TC) ? 8'h00 : cnt + 8'h01;
  endfunction

endpackage : dsm_pkg
`default_nettype wire

// File: rtl/sample_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : sample_fifo_mem
//  Purpose  : DEPTH x SAMPLE_W simple dual-port register array. One
//             synchronous write port, one asynchronous read port that
//             presents the FIFO head.
//  Ports    : clk      - rising-edge clock
//             wr_en    - write strobe
//             wr_addr  - write address (tail pointer)
//             wr_data  - sample to store
//             rd_addr  - read address (head pointer)
//             rd_data  - sample at rd_addr, combinational
//  Revision : 1.0  initial release
// ============================================================================
module sample_fifo_mem
  import dsm_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  // Storage is deliberately not reset; validity is tracked by the pointers.
  sample_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule : sample_fifo_mem
`default_nettype wire

// File: rtl/pcm_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : pcm_sample_feeder
//  Purpose  : Buffers 16-bit unsigned PCM samples from a valid/ready
//             producer and presents one stable sample to the delta-sigma
//             modulator, advancing on each pull. Underruns are handled
//             deterministically and flagged with a sticky bit.
//  Ports    : clk            - rising-edge clock
//             reset          - asynchronous active-high reset
//             in_data        - PCM sample from producer
//             in_valid       - in_data valid
//             in_ready       - FIFO can accept (level != DEPTH)
//             pull           - modulator consumes samp at this edge
//             samp           - presented sample, registered
//             level          - FIFO occupancy, registered
//             underrun       - sticky underrun flag
//             clr_underrun   - synchronous clear of underrun (wins over set)
//             underrun_count - saturating underrun counter
//                              (present only with FEEDER_STATS_EN defined)
//  Options  : `define FEEDER_STATS_EN adds the underrun_count output.
//  Revision : 1.0  initial release
// ============================================================================
module pcm_sample_feeder
  import dsm_pkg::*;
#(
  parameter int      DEPTH         = 16,
  parameter sample_t IDLE_VALUE    = 16'h8000,
  parameter bit      UNDERRUN_HOLD = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SAMPLE_W-1:0]      in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     pull,
  output logic [SAMPLE_W-1:0]      samp,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  input  logic                     clr_underrun
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]              underrun_count
`endif
);

  localparam int                   c_PTR_W   = $clog2(DEPTH);
  localparam int                   c_LEVEL_W = c_PTR_W + 1;
  localparam logic [c_LEVEL_W-1:0] c_FULL    = c_LEVEL_W'(DEPTH);
  localparam logic [c_LEVEL_W-1:0] c_EMPTY   = '0;

  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_LEVEL_W-1:0] r_level;
  sample_t              r_samp;
  logic                 r_underrun;
  sample_t              w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_underrun_evt;

  // Readiness depends only on the registered level: no pull->in_ready path.
  assign in_ready       = (r_level != c_FULL);
  assign w_push         = in_valid && in_ready;
  // A push landing this same edge is not visible to the pull (no bypass).
  assign w_pop          = pull && (r_level != c_EMPTY);
  assign w_underrun_evt = pull && (r_level == c_EMPTY);

  sample_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (c_PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (in_data),
    .rd_addr (r_rd_ptr),
    .rd_data (w_head)
  );

  // Pointers wrap naturally modulo DEPTH (power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_samp <= IDLE_VALUE;
    end else if (w_pop) begin
      r_samp <= w_head;
    end else if (w_underrun_evt) begin
      r_samp <= UNDERRUN_HOLD ? r_samp : IDLE_VALUE;
    end
  end

  // Clear beats a simultaneous underrun event; that event is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underrun <= 1'b0;
    end else if (clr_underrun) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_evt) begin
      r_underrun <= 1'b1;
    end
  end

`ifdef FEEDER_STATS_EN
  logic [15:0] r_underrun_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underrun_count <= '0;
    end else if (clr_underrun) begin
      r_underrun_count <= '0;
    end else if (w_underrun_evt && (r_underrun_count != 16'hFFFF)) begin
      r_underrun_count <= r_underrun_count + 16'h0001;
    end
  end

  assign underrun_count = r_underrun_count;
`endif

  assign samp     = r_samp;
  assign level    = r_level;
  assign underrun = r_underrun;

endmodule : pcm_sample_feeder
`default_nettype wire

// File: tb/tb_pcm_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcm_sample_feeder
//  Purpose  : Self-checking bench for pcm_sample_feeder (DEPTH=16,
//             IDLE_VALUE=8000, UNDERRUN_HOLD=0). Table-driven vectors plus
//             hand-written sequences for fill, wrap, reset and statistics.
//  Options  : `define FEEDER_STATS_EN to exercise underrun_count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pcm_sample_feeder;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        pull;
  logic [15:0] samp;
  logic [4:0]  level;
  logic        underrun;
  logic        clr_underrun;
`ifdef FEEDER_STATS_EN
  logic [15:0] underrun_count;
`endif

  int checks = 0;
  int errors = 0;

  pcm_sample_feeder #(
    .DEPTH         (16),
    .IDLE_VALUE    (16'h8000),
    .UNDERRUN_HOLD (1'b0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pull         (pull),
    .samp         (samp),
    .level        (level),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
`ifdef FEEDER_STATS_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] din;
    logic        vld;
    logic        pul;
    logic        clr;
    logic [15:0] e_samp;
    logic [4:0]  e_level;
    logic        e_ur;
    logic        e_rdy;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic v, input logic p, input logic c);
    in_data      = d;
    in_valid     = v;
    pull         = p;
    clr_underrun = c;
  endtask

  // Apply current inputs across one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Inputs -> expected outputs after the edge.
    tbl[0]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h8000, 5'd0, 1'b1, 1'b1}; // pull on empty
    tbl[1]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h8000, 5'd0, 1'b0, 1'b1}; // clear flag
    tbl[2]  = '{16'h1234, 1'b1, 1'b0, 1'b0, 16'h8000, 5'd1, 1'b0, 1'b1};
    tbl[3]  = '{16'hABCD, 1'b1, 1'b0, 1'b0, 16'h8000, 5'd2, 1'b0, 1'b1};
    tbl[4]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234, 5'd1, 1'b0, 1'b1};
    tbl[5]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'hABCD, 5'd0, 1'b0, 1'b1};
    tbl[6]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h8000, 5'd0, 1'b1, 1'b1}; // underrun
    tbl[7]  = '{16'h5555, 1'b1, 1'b1, 1'b0, 16'h8000, 5'd1, 1'b1, 1'b1}; // no bypass
    tbl[8]  = '{16'h0000, 1'b0, 1'b1, 1'b1, 16'h5555, 5'd0, 1'b0, 1'b1};
    tbl[9]  = '{16'h0000, 1'b0, 1'b1, 1'b1, 16'h8000, 5'd0, 1'b0, 1'b1}; // clear wins
    tbl[10] = '{16'h0001, 1'b1, 1'b0, 1'b0, 16'h8000, 5'd1, 1'b0, 1'b1};
    tbl[11] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h8000, 5'd2, 1'b0, 1'b1};
    tbl[12] = '{16'h0000, 1'b1, 1'b0, 1'b0, 16'h8000, 5'd3, 1'b0, 1'b1};
    tbl[13] = '{16'h7777, 1'b1, 1'b1, 1'b0, 16'h0001, 5'd3, 1'b0, 1'b1}; // push+pop
    tbl[14] = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 5'd2, 1'b0, 1'b1};
    tbl[15] = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b1};
    tbl[16] = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h7777, 5'd0, 1'b0, 1'b1};

    reset = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("reset_samp",  samp,     32'h8000);
    check("reset_level", level,    32'd0);
    check("reset_ur",    underrun, 32'd0);
    check("reset_rdy",   in_ready, 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].din, tbl[i].vld, tbl[i].pul, tbl[i].clr);
      step();
      check($sformatf("vec%0d_samp", i),  samp,     32'(tbl[i].e_samp));
      check($sformatf("vec%0d_level", i), level,    32'(tbl[i].e_level));
      check($sformatf("vec%0d_ur", i),    underrun, 32'(tbl[i].e_ur));
      check($sformatf("vec%0d_rdy", i),   in_ready, 32'(tbl[i].e_rdy));
    end

    // Fill to DEPTH, refuse the extra push, then pull with valid still high.
    for (int i = 0; i < 16; i++) begin
      drive(16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0);
      step();
      check($sformatf("fill%0d_level", i), level, 32'(i + 1));
    end
    check("full_rdy", in_ready, 32'd0);
    drive(16'hDEAD, 1'b1, 1'b0, 1'b0);
    step();
    check("full_refuse_level", level, 32'd16);
    check("full_refuse_rdy",   in_ready, 32'd0);
    drive(16'hDEAD, 1'b1, 1'b1, 1'b0);
    step();
    check("full_pull_samp",  samp,     32'h1000);
    check("full_pull_level", level,    32'd15);
    check("full_pull_rdy",   in_ready, 32'd1);
    for (int k = 1; k < 16; k++) begin
      drive(16'h0000, 1'b0, 1'b1, 1'b0);
      step();
      check($sformatf("drain%0d_samp", k), samp, 32'(16'h1000 + 16'(k)));
    end
    check("drain_level", level, 32'd0);
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    step();
    check("drain_end_samp", samp,     32'h8000);
    check("drain_end_ur",   underrun, 32'd1);
    drive(16'h0000, 1'b0, 1'b0, 1'b1);
    step();

    // Level 3, then concurrent push+pull across 2*DEPTH pushes (pointer wrap).
    for (int i = 0; i < 3; i++) begin
      drive(16'h2000 + 16'(i), 1'b1, 1'b0, 1'b0);
      step();
    end
    check("wrap_pre_level", level, 32'd3);
    for (int k = 0; k < 32; k++) begin
      drive(16'h2003 + 16'(k), 1'b1, 1'b1, 1'b0);
      step();
      check($sformatf("wrap%0d_samp", k),  samp,  32'(16'h2000 + 16'(k)));
      check($sformatf("wrap%0d_level", k), level, 32'd3);
    end
    check("wrap_ur", underrun, 32'd0);

    // Grow to level 5, then an asynchronous reset between edges.
    drive(16'h3000, 1'b1, 1'b0, 1'b0);
    step();
    drive(16'h3001, 1'b1, 1'b0, 1'b0);
    step();
    check("prereset_level", level, 32'd5);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_level", level,    32'd0);
    check("async_samp",  samp,     32'h8000);
    check("async_rdy",   in_ready, 32'd1);
    step();
    reset = 1'b0;
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    step();
    check("post_reset_samp",  samp,     32'h8000);
    check("post_reset_ur",    underrun, 32'd1);
    check("post_reset_level", level,    32'd0);

`ifdef FEEDER_STATS_EN
    drive(16'h0000, 1'b0, 1'b0, 1'b1);
    step();
    check("stats_clr0", underrun_count, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(16'h0000, 1'b0, 1'b1, 1'b0);
      step();
    end
    check("stats_three", underrun_count, 32'd3);
    drive(16'h0000, 1'b0, 1'b0, 1'b1);
    step();
    check("stats_clr_cnt", underrun_count, 32'd0);
    check("stats_clr_ur",  underrun,       32'd0);
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 65540; k++) begin
      @(posedge clk);
    end
    #1;
    check("stats_sat", underrun_count, 32'hFFFF);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pcm_sample_feeder
`default_nettype wire

// File: doc/pcm_sample_feeder.md
Name: pcm_sample_feeder

Overview:
- Upstream stage of the delta-sigma modulator. Buffers 16-bit unsigned PCM samples arriving on a valid/ready stream.
- Presents one stable sample on `samp` and advances to the next sample each time the modulator asserts `pull` (once per 256-clock oversample frame, plus once just after reset).
- Absorbs producer burstiness and handles underrun deterministically.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- IDLE_VALUE, 16'h8000, sample presented after reset and on underrun when UNDERRUN_HOLD=0 (unsigned mid-scale).
- UNDERRUN_HOLD, 0, 1 = repeat last presented sample on underrun; 0 = present IDLE_VALUE.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- in_data  in  16  unsigned PCM sample from producer
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready at a rising edge
- pull  in  1  modulator request; sample consumed at the rising edge where pull=1
- samp  out  16  presented sample, registered, stable between pulls
- level  out  $clog2(DEPTH)+1  FIFO occupancy, registered
- underrun  out  1  sticky; set when pull occurs with the FIFO empty
- clr_underrun  in  1  synchronous clear of underrun

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, reset).
- Reset values:
  - samp=IDLE_VALUE, level=0, underrun=0, in_ready=1.
  - FIFO pointers cleared; storage contents need not be reset.
- Reset mid-operation discards all buffered samples immediately. The first pull after reset sees IDLE_VALUE.
- in_ready = (level != DEPTH). It is derived from registered level only, so there is no combinational path from pull to in_ready.
- Push: in_valid && in_ready writes in_data at the tail; level+1.
- Pop, on a pull edge:
  - The modulator latches the current samp at this same edge.
  - If level>0: samp <= head entry, head advances, level-1.
  - If level==0: samp <= (UNDERRUN_HOLD ? samp : IDLE_VALUE), underrun <= 1, pointers unchanged.
- Latency:
  - A sample pushed into an empty FIFO becomes visible on samp only after the next pull edge. It is consumed by the modulator at the pull after that (one-frame prefetch).
  - First-in first-out ordering is always preserved.
- Simultaneous events:
  - Push and pop in the same cycle with level>0: level unchanged, both pointers advance.
  - Push into an empty FIFO concurrent with pull: there is no bypass. The pull counts as an underrun and the pushed sample lands in the FIFO with level=1.
  - When full, pushes are refused (in_ready=0) even if a pull occurs that cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in a separate counter.
- Underrun priority: clr_underrun has priority over set in the same cycle. Clear takes effect and the new event is lost; this is intentional for simplicity.
- pull is level-sensitive per cycle. N consecutive pull cycles pop N samples. The modulator never pulls twice in adjacent cycles except at reset exit, when RESET-state pull is followed by counter value FF.

Optional Feature:
- Macro FEEDER_STATS_EN.
- Defined:
  - Adds output underrun_count [15:0], reset 0.
  - Increments on every underrun pull event, saturating at 16'hFFFF.
  - Cleared by clr_underrun together with the sticky flag.
- Undefined: port and counter absent. All other behaviour is identical.

Decomposition:
- Shared package dsm_pkg:
  - SAMPLE_W=16, OSR=256 (oversample counter terminal count 8'hFF).
  - THRESHOLD constant, and typedef sample_t logic [SAMPLE_W-1:0].
  - The modulator and this feeder both import it.
- One natural sub-module: sample_fifo_mem, a DEPTH x 16 simple dual-port register array with one write port and an asynchronous read of the head.
- Pointer, level and underrun logic stay in pcm_sample_feeder.

Test Plan:
- Reset then pull with no pushes: samp=16'h8000 before and after the pull, underrun=1, level=0.
- Push 16'h1234, 16'hABCD; pull, pull, pull: samp becomes 1234, then ABCD, then 8000 (hold=0) or ABCD (hold=1). underrun set only on the third pull.
- Push 16 samples without pull: level=16, in_ready=0. A 17th in_valid is not accepted; after one pull, level=15 and in_ready=1.
- Level=3, push and pull in the same cycle: level stays 3, and ordering is preserved across 2*DEPTH pushes (pointer wrap).
- Assert reset for 1 cycle while level=5: level=0, samp=8000, in_ready=1 immediately (asynchronous).
- FEEDER_STATS_EN: 3 underrun pulls give underrun_count=3; clr_underrun gives 0 and underrun=0. Forcing 65540 underruns saturates at FFFF.
